// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode constants and sequencer state encoding shared by the ALU sequencer files
package ula_pkg;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_XOR       = 3'b010;
  localparam logic [2:0] OP_NOT       = 3'b011;
  localparam logic [2:0] OP_LEGAL_MAX = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    CAPT = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_LEGAL_MAX;
  endfunction

endpackage

// File: rtl/ula_modelo.sv
// rtl/ula_modelo.sv - combinational reference {flag, result} of the 8-bit ALU for a given (a, b, op)
module ula_modelo
  import ula_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] result,
  output logic         flag
);

  logic [N:0] sum;
  logic [N:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (op)
      OP_ADD:  {flag, result} = sum;
      OP_SUB:  {flag, result} = dif;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_sequenciador.sv
// rtl/ula_sequenciador.sv - command/result sequencer for the 8-bit ALU; optional checker under ULA_SEQUENCIADOR_CHECK_EN
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int N       = 8,
  parameter int ULA_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_chain,
  output logic [N-1:0] ula_a,
  output logic [N-1:0] ula_b,
  output logic [2:0]   ula_op,
  input  logic [N-1:0] ula_s,
  input  logic         ula_flag,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_flag,
  output logic         res_err
`ifdef ULA_SEQUENCIADOR_CHECK_EN
  ,
  output logic         res_mismatch
`endif
);

  localparam int CW = (ULA_LAT > 1) ? $clog2(ULA_LAT) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;
  logic          cmd_legal;

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_legal = op_legal(cmd_op);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal) begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(ULA_LAT - 1);
          end else begin
            state_nxt = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = CAPT;
        else           cnt_nxt   = cnt - CW'(1);
      end
      CAPT: state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ula_* stay put outside a legal accept so the ALU flag tracks the last real operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ula_a    <= '0;
      ula_b    <= '0;
      ula_op   <= OP_ADD;
      res_data <= '0;
      res_flag <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        if (cmd_legal) begin
          ula_a  <= cmd_chain ? res_data : cmd_a;
          ula_b  <= cmd_b;
          ula_op <= cmd_op;
        end else begin
          res_data <= '0;
          res_flag <= 1'b0;
          res_err  <= 1'b1;
        end
      end
      if (state == CAPT) begin
        res_data <= ula_s;
        res_flag <= ula_flag;
        res_err  <= 1'b0;
      end
    end
  end

`ifdef ULA_SEQUENCIADOR_CHECK_EN
  logic [N-1:0] exp_res;
  logic         exp_flag;

  ula_modelo #(.N(N)) u_modelo (
    .a      (ula_a),
    .b      (ula_b),
    .op     (ula_op),
    .result (exp_res),
    .flag   (exp_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_mismatch <= 1'b0;
    end else if (accept && !cmd_legal) begin
      res_mismatch <= 1'b0;
    end else if (state == CAPT) begin
      res_mismatch <= (exp_res != ula_s) || (exp_flag != ula_flag);
    end
  end
`else
`endif

endmodule
